// File: rtl/immd_gen_pipe.sv
`timescale 1ns/1ps
// Pipelined immediate generator with a 2-entry skid buffer.
// Optional: IMMD_SHAMT_EN zero-extends shamt for shift-immediates.
module immd_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       instr_type,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immd_out,
  output logic [2:0]       instr_type_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [2:0] NOP_TYPE = 3'd0;
  localparam logic [2:0] R_TYPE   = 3'd1;
  localparam logic [2:0] I_TYPE   = 3'd2;
  localparam logic [2:0] S_TYPE   = 3'd3;
  localparam logic [2:0] B_TYPE   = 3'd4;
  localparam logic [2:0] U_TYPE   = 3'd5;
  localparam logic [2:0] J_TYPE   = 3'd6;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  immd;
    logic [2:0]       itype;
    logic [TAG_W-1:0] tag;
  } ent_t;

  state_t state_q, state_d;
  ent_t   main_q, main_d;
  ent_t   skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  ent_t   new_ent;
  logic   [31:0] w;
  logic   is_i, is_s, is_b, is_u, is_j;
  logic   acc, dlv;
  logic   unused_opc;

  assign unused_opc = ^{instr[6:0], R_TYPE};

  always_comb begin
    is_i = (instr_type == I_TYPE);
    is_s = (instr_type == S_TYPE);
    is_b = (instr_type == B_TYPE);
    is_u = (instr_type == U_TYPE);
    is_j = (instr_type == J_TYPE);
    w = '0;
    unique case (1'b1)
      is_i: w = {{20{instr[31]}}, instr[31:20]};
      is_s: w = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      is_b: w = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
      is_u: w = {instr[31:12], 12'b0};
      is_j: w = {{11{instr[31]}}, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
      default: w = '0;
    endcase
`ifdef IMMD_SHAMT_EN
    // shift-immediates carry funct7 in the upper field; keep shamt only
    if (is_i && instr[6:0] == 7'b0010011 && instr[13:12] == 2'b01)
      w = {26'b0, (XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
`endif
    new_ent.immd  = XLEN'($signed(w));
    new_ent.itype = instr_type;
    new_ent.tag   = tag_in;
  end

  assign acc = in_valid & in_ready_q;
  assign dlv = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = new_ent;
            state_d = ONE;
          end
        end
        ONE: begin
          if (acc && dlv) begin
            main_d = new_ent;
          end else if (acc) begin
            skid_d  = new_ent;
            state_d = TWO;
          end else if (dlv) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (dlv) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '{immd: '0, itype: NOP_TYPE, tag: '0};
      skid_q     <= '{immd: '0, itype: NOP_TYPE, tag: '0};
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (state_q != EMPTY);
  assign immd_out       = main_q.immd;
  assign instr_type_out = main_q.itype;
  assign tag_out        = main_q.tag;

endmodule

// File: doc/immd_gen_pipe.md
Name: immd_gen_pipe

Overview:
Pipelined, parametrised successor to the combinational immediate generator in the decode path. Accepts one instruction per cycle through a valid/ready handshake and decodes the I/S/B/U/J immediate, sign-extended to XLEN. Registers the result alongside a pass-through tag, and holds it behind a 2-entry skid buffer so back-pressure from execute never drops or duplicates an instruction. Sits between fetch/decode and the register-read/execute stage; supports pipeline flush.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64; sign-extension fills bits XLEN-1 down to the field MSB.
TAG_W, 32, width of the opaque side-band tag (normally the PC) carried with each instruction.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; discards all buffered entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction this cycle
instr  in  32  raw instruction word
instr_type  in  3  decoded type, encoded with the defines.vh macros: NOP_TYPE, R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
tag_in  in  TAG_W  side-band tag
out_valid  out  1  immediate valid downstream
out_ready  in  1  downstream accepts
immd_out  out  XLEN  sign-extended immediate
instr_type_out  out  3  registered copy of instr_type
tag_out  out  TAG_W  registered copy of tag_in

Behaviour:
- Reset (rst_n low, async): out_valid=0, in_ready=0 while asserted, immd_out=0, instr_type_out=NOP_TYPE, tag_out=0, both buffer slots empty. First cycle after deassertion: in_ready=1.
- Accept when in_valid & in_ready; deliver when out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid with an empty buffer. Throughput: 1 per cycle while out_ready=1.
- Storage: main slot (drives outputs) plus skid slot. in_ready = skid slot empty; it is a registered output, never combinational from out_ready.
- FSM: EMPTY (no entries), ONE (main full), TWO (main and skid full).
  - EMPTY: accept -> ONE.
  - ONE: accept and deliver -> ONE, main reloaded; accept only -> TWO, skid loaded; deliver only -> EMPTY.
  - TWO: in_ready=0; deliver -> ONE, skid moves to main; otherwise hold.
- Immediate formation, computed before the register:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All four are sign-extended from instr[31].
  - U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - R_TYPE, NOP_TYPE and unknown encodings: 0.
- Held outputs stay stable while out_valid=1 and out_ready=0.
- flush: next cycle EMPTY, out_valid=0, in_ready=1. An accept in the same cycle as flush is discarded. flush has priority over every handshake.
- Reset mid-operation discards everything immediately (async).

Optional Feature:
IMMD_SHAMT_EN. When defined, an I_TYPE with opcode 0010011 and funct3 001 or 101 (shift-immediate) yields immd_out = zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. Funct7 bits are excluded. When undefined, shifts get the normal I-type sign-extended immediate.

Test Plan:
- Streaming, XLEN=32, out_ready=1. Inputs back-to-back: I 0x02238693, S 0x58622c23, B 0x35bb8ee3, U 0x07c9fbb7, J 0x29e4f36f, R 0xDEADBEEF. Expected immd_out on consecutive cycles, each one cycle after its accept: 0x00000022, 0x00000598, 0x00000B5C, 0x07C9F000, 0x0004F29E, 0x00000000. Tags are preserved in order.
- Sign extension: I 0xFFF00093 gives 0xFFFFFFFF at XLEN=32 and 0xFFFFFFFFFFFFFFFF at XLEN=64. U 0x80000037 at XLEN=64 gives 0xFFFFFFFF80000000.
- Back-pressure: hold out_ready=0 and offer 3 instructions. Exactly 2 are accepted and in_ready falls the cycle after the second. Raise out_ready: outputs drain in order with no loss or duplication, then in_ready returns to 1.
- Flush: in state TWO, assert flush together with in_valid. Next cycle out_valid=0 and in_ready=1; the flushed instruction never appears.
- Async reset: pull rst_n low mid-stream between clock edges. Outputs clear immediately to out_valid=0, immd_out=0, instr_type_out=NOP_TYPE.
- Shift: I 0x40515093 (srai x1,x2,5) gives 0x00000005 with IMMD_SHAMT_EN defined and 0x00000405 without it.
